// File: rtl/serial_subtractor_30_if.sv
// serial_subtractor_30_if
//   Groups the request and result signals of the bit-serial subtractor.
//   master: drives start/a/b/bin and receives busy/done/d/bout/zero/dbg_state.
//   slave : the subtractor itself.
//   Handshake: a request is accepted on a rising clk edge where start=1 and the
//   subtractor is not busy (idle or in its done cycle). Operands are captured on
//   that edge only. done is a one-cycle pulse marking d/bout/zero as fresh;
//   there is no backpressure on the result side.
interface serial_subtractor_30_if #(
   parameter int WIDTH = 30
);
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             bin;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] d;
   logic             bout;
   logic             zero;
   logic [1:0]       dbg_state;

   modport master (
      output start, a, b, bin,
      input  busy, done, d, bout, zero, dbg_state
   );

   modport slave (
      input  start, a, b, bin,
      output busy, done, d, bout, zero, dbg_state
   );
endinterface

// File: rtl/serial_subtractor_30.sv
// serial_subtractor_30
//   Bit-serial word-address subtractor: d = a - b - bin, one bit per clock,
//   LSB first, through a single full-subtractor slice.
//   Ports:
//     clk  - rising-edge clock
//     nrst - synchronous active-low reset
//     bus  - serial_subtractor_30_if.slave (start/a/b/bin in,
//            busy/done/d/bout/zero/dbg_state out)
//   Latency: start accepted at edge E, done high in the cycle after E+WIDTH.
//   d/bout/zero change only on entry to DONE and hold until the next result.
module serial_subtractor_30 #(
   parameter int WIDTH = 30
) (
   input  logic                   clk,
   input  logic                   nrst,
   serial_subtractor_30_if.slave  bus
);
   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_sr_q, a_sr_d;
   logic [WIDTH-1:0] b_sr_q, b_sr_d;
   logic [WIDTH-1:0] d_sr_q, d_sr_d;
   logic             brw_q, brw_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] d_q, d_d;
   logic             bout_q, bout_d;
   logic             zero_q, zero_d;

   logic             diff;
   logic             brw_next;
   logic [WIDTH-1:0] d_shift;

   // Full-subtractor slice on the current LSBs.
   always_comb begin
      diff     = a_sr_q[0] ^ b_sr_q[0] ^ brw_q;
      brw_next = (~a_sr_q[0] & b_sr_q[0]) | (~(a_sr_q[0] ^ b_sr_q[0]) & brw_q);
      d_shift  = {diff, d_sr_q[WIDTH-1:1]};
   end

   always_comb begin
      state_d = state_q;
      a_sr_d  = a_sr_q;
      b_sr_d  = b_sr_q;
      d_sr_d  = d_sr_q;
      brw_d   = brw_q;
      cnt_d   = cnt_q;
      d_d     = d_q;
      bout_d  = bout_q;
      zero_d  = zero_q;

      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (bus.start) begin
               a_sr_d  = bus.a;
               b_sr_d  = bus.b;
               brw_d   = bus.bin;
               cnt_d   = '0;
               state_d = ST_BUSY;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_BUSY: begin
            a_sr_d = a_sr_q >> 1;
            b_sr_d = b_sr_q >> 1;
            d_sr_d = d_shift;
            brw_d  = brw_next;
            cnt_d  = cnt_q + CW'(1);
            // Last bit: publish the completed word together with the final
            // borrow, so d never shows a partially shifted value.
            if (cnt_q == CW'(WIDTH - 1)) begin
               state_d = ST_DONE;
               cnt_d   = '0;
               d_d     = d_shift;
               bout_d  = brw_next;
               zero_d  = (d_shift == '0);
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!nrst) begin
         state_q <= ST_IDLE;
         a_sr_q  <= '0;
         b_sr_q  <= '0;
         d_sr_q  <= '0;
         brw_q   <= 1'b0;
         cnt_q   <= '0;
         d_q     <= '0;
         bout_q  <= 1'b0;
         zero_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         a_sr_q  <= a_sr_d;
         b_sr_q  <= b_sr_d;
         d_sr_q  <= d_sr_d;
         brw_q   <= brw_d;
         cnt_q   <= cnt_d;
         d_q     <= d_d;
         bout_q  <= bout_d;
         zero_q  <= zero_d;
      end
   end

   assign bus.busy      = (state_q == ST_BUSY);
   assign bus.done      = (state_q == ST_DONE);
   assign bus.d         = d_q;
   assign bus.bout      = bout_q;
   assign bus.zero      = zero_q;
   assign bus.dbg_state = state_q;
endmodule

// File: tb/tb_serial_subtractor_30.sv
// tb_serial_subtractor_30
//   Drives requests into serial_subtractor_30 and compares each result with
//   a plain-arithmetic reference held in an expected queue.
module tb_serial_subtractor_30;
   localparam int W = 30;
   localparam logic [W-1:0] MASK = {W{1'b1}};

   logic clk;
   logic nrst;

   serial_subtractor_30_if #(.WIDTH(W)) bus ();

   serial_subtractor_30 #(.WIDTH(W)) dut (
      .clk  (clk),
      .nrst (nrst),
      .bus  (bus)
   );

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- scoreboard ----------------
   // Packed expectation: [31]=zero, [30]=bout, [29:0]=d
   logic [31:0]  exp_q[$];
   logic [W-1:0] last_d;
   int           n_pass;
   int           n_total;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   function automatic logic [31:0] ref_sub(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic bin);
      logic [W:0] r;
      r = {1'b0, a} - {1'b0, b} - (W+1)'(bin);
      return {(r[W-1:0] == '0), r[W], r[W-1:0]};
   endfunction

   // ---------------- driver tasks ----------------
   // Called at a negedge; the request is accepted at the following posedge.
   task automatic drive_req(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
      bus.start = 1'b1;
      bus.a     = a;
      bus.b     = b;
      bus.bin   = bin;
      exp_q.push_back(ref_sub(a, b, bin));
   endtask

   // Waits for done; returns at the negedge where done is visible, so a caller
   // may assert a new start during the done cycle. poke>0 pulses a stray
   // start (a=b=7) at that busy cycle, which must be ignored.
   task automatic wait_result(input string tag, input int poke);
      logic [31:0] e;
      bit          seen;
      seen = 1'b0;
      for (int k = 1; k <= 40 && !seen; k++) begin
         @(negedge clk);
         if (k == 1) begin
            bus.start = 1'b0;
            bus.a     = W'($urandom) & MASK;
            bus.b     = W'($urandom) & MASK;
            bus.bin   = 1'($urandom_range(0, 1));
            check_eq({tag, "_busy1"}, 32'(bus.busy), 32'd1);
         end
         if (poke != 0 && k == poke) begin
            bus.start = 1'b1;
            bus.a     = 30'd7;
            bus.b     = 30'd7;
            bus.bin   = 1'b0;
         end else if (poke != 0 && k == poke + 1) begin
            bus.start = 1'b0;
         end
         if (k == 15) check_eq({tag, "_dhold"}, 32'(bus.d), 32'(last_d));
         if (bus.done) begin
            seen = 1'b1;
            e = exp_q.pop_front();
            check_eq({tag, "_lat"}, 32'(k), 32'd31);
            check_eq({tag, "_d"}, 32'(bus.d), {2'b00, e[W-1:0]});
            check_eq({tag, "_bout"}, 32'(bus.bout), 32'(e[30]));
            check_eq({tag, "_zero"}, 32'(bus.zero), 32'(e[31]));
            last_d = e[W-1:0];
         end
      end
      if (!seen) begin
         check_eq({tag, "_timeout"}, 32'd0, 32'd1);
         if (exp_q.size() > 0) void'(exp_q.pop_front());
      end
   endtask

   // One cycle after a result with no new start: back to idle, result held.
   task automatic check_idle(input string tag);
      @(negedge clk);
      check_eq({tag, "_done_off"}, 32'(bus.done), 32'd0);
      check_eq({tag, "_idle"}, 32'(bus.busy), 32'd0);
      check_eq({tag, "_held"}, 32'(bus.d), 32'(last_d));
   endtask

   // ---------------- main sequence ----------------
   initial begin
      n_pass    = 0;
      n_total   = 0;
      last_d    = '0;
      nrst      = 1'b0;
      bus.start = 1'b0;
      bus.a     = '0;
      bus.b     = '0;
      bus.bin   = 1'b0;
      repeat (3) @(negedge clk);
      check_eq("rst_busy", 32'(bus.busy), 32'd0);
      check_eq("rst_done", 32'(bus.done), 32'd0);
      check_eq("rst_d", 32'(bus.d), 32'd0);
      check_eq("rst_bout", 32'(bus.bout), 32'd0);
      check_eq("rst_zero", 32'(bus.zero), 32'd0);
      nrst = 1'b1;
      @(negedge clk);

      drive_req(30'd5, 30'd3, 1'b0);
      wait_result("t1", 0);
      check_idle("t1");

      drive_req(30'd0, 30'd1, 1'b0);
      wait_result("t2_wrap", 0);
      check_idle("t2");

      drive_req(30'h2AAAAAAA, 30'h2AAAAAA9, 1'b1);
      wait_result("t3_zero", 0);
      check_idle("t3");

      drive_req(30'd1000, 30'd24, 1'b0);
      wait_result("t4_ignore", 10);
      check_idle("t4");

      // back-to-back: new start asserted during the done cycle
      drive_req(30'd50, 30'd60, 1'b1);
      wait_result("t5a", 0);
      drive_req(30'd100, 30'd1, 1'b0);
      wait_result("t5b", 0);
      check_idle("t5");

      // boundaries and random operands
      drive_req(MASK, MASK, 1'b1);
      wait_result("bnd_all1", 0);
      drive_req(30'd0, MASK, 1'b1);
      wait_result("bnd_max", 0);
      for (int i = 0; i < 12; i++) begin
         drive_req(W'($urandom) & MASK, W'($urandom) & MASK, 1'($urandom_range(0, 1)));
         wait_result("rnd", 0);
         if ($urandom_range(0, 1) == 1) check_idle("rnd");
      end
      check_idle("rnd_end");

      // reset in the middle of an operation
      bus.start = 1'b1;
      bus.a     = 30'd12345;
      bus.b     = 30'd345;
      bus.bin   = 1'b0;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (14) @(negedge clk);
      nrst = 1'b0;
      @(negedge clk);
      nrst = 1'b1;
      check_eq("abort_busy", 32'(bus.busy), 32'd0);
      check_eq("abort_done", 32'(bus.done), 32'd0);
      check_eq("abort_d", 32'(bus.d), 32'd0);
      check_eq("abort_bout", 32'(bus.bout), 32'd0);
      begin
         int dones;
         dones = 0;
         for (int k = 0; k < 25; k++) begin
            @(negedge clk);
            if (bus.done) dones++;
         end
         check_eq("abort_no_done", 32'(dones), 32'd0);
      end
      last_d = '0;
      drive_req(30'd12345, 30'd345, 1'b0);
      wait_result("t6_fresh", 0);
      check_idle("t6");

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
